// File: rtl/wbc_lineclk_pkg.sv
// Shared constants and types for the line-time clock peripheral.
package wbc_lineclk_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned VEC_W  = 9;

  localparam logic [DATA_W-1:0] CSR_ADDR = 16'o177546;

  localparam int unsigned OVR_BIT = 8;
  localparam int unsigned MON_BIT = 7;
  localparam int unsigned IE_BIT  = 6;

  localparam logic [VEC_W-1:0] DEFAULT_VECTOR = 9'o100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_REARM = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic ovr;
    logic mon;
    logic ie;
  } csr_t;

  // Place the live CSR fields at their bus bit positions; the rest read 0.
  function automatic logic [DATA_W-1:0] csr_pack(input csr_t c);
    logic [DATA_W-1:0] w;
    w          = '0;
    w[OVR_BIT] = c.ovr;
    w[MON_BIT] = c.mon;
    w[IE_BIT]  = c.ie;
    return w;
  endfunction

endpackage

// File: rtl/wbc_edge_sync.sv
// Optional 2-flop synchronizer followed by a rising-edge detector.
// Flops preset to 1 so a level already high at reset release is not an edge.
module wbc_edge_sync #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic init_i,
  input  logic d_i,
  output logic rise_c_o
);

  logic lvl_c;
  logic hist_q;

  if (SYNC) begin : g_sync
    logic s1_q;
    logic s2_q;

    // Two-stage synchronizer into the clk_i domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_q <= 1'b1;
        s2_q <= 1'b1;
      end else begin
        s1_q <= d_i;
        s2_q <= s1_q;
      end
    end

    assign lvl_c = s2_q;
  end else begin : g_nosync
    assign lvl_c = d_i;
  end

  // History register; during init it simply absorbs the current level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= lvl_c;
    end
  end

  assign rise_c_o = lvl_c & ~hist_q & ~init_i;

endmodule

// File: rtl/wbc_lineclk.sv
// Line-time clock CSR (MON/IE/OVR) with a vectored request/acknowledge interrupt.
module wbc_lineclk
  import wbc_lineclk_pkg::*;
#(
  parameter logic [VEC_W-1:0] VECTOR = DEFAULT_VECTOR,
  parameter bit               SYNC   = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              sys_init,
  input  logic              tick,
  input  logic              ltc_ena,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              irq,
  output logic [VEC_W-1:0]  ivec,
  input  logic              iack
);

  logic       rise_c;
  logic       qtick_c;
  logic       req_c;
  logic       wr_lo_c;
  logic       wr_hi_c;
  logic       ie_clr_c;
  logic       rearm_ok_c;
  csr_t       csr_q;
  csr_t       csr_d;
  irq_state_e state_q;
  logic       irq_q;
  logic       ack_q;
  logic [DATA_W-1:0] dat_q;
  logic       unused_dat_c;

  wbc_edge_sync #(
    .SYNC (SYNC)
  ) u_edge (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .init_i   (sys_init),
    .d_i      (tick),
    .rise_c_o (rise_c)
  );

  assign req_c      = wb_cyc_i & wb_stb_i;
  assign wr_lo_c    = req_c & wb_we_i & wb_sel_i[0];
  assign wr_hi_c    = req_c & wb_we_i & wb_sel_i[1];
  assign qtick_c    = rise_c & ltc_ena;
  assign ie_clr_c   = wr_lo_c & ~wb_dat_i[IE_BIT];
  assign rearm_ok_c = csr_q.ie & ~ie_clr_c;

  assign unused_dat_c = ^{wb_dat_i[DATA_W-1:MON_BIT+1], wb_dat_i[IE_BIT-1:0]};

  // CSR next state: software writes first, a tick overrides MON and may flag overrun.
  always_comb begin
    csr_d = csr_q;
    if (wr_lo_c) begin
      csr_d.mon = wb_dat_i[MON_BIT];
      csr_d.ie  = wb_dat_i[IE_BIT];
    end
    if (wr_hi_c) begin
      csr_d.ovr = 1'b0;
    end
    if (qtick_c) begin
      csr_d.mon = 1'b1;
      if (state_q == ST_REQ && !iack) begin
        csr_d.ovr = 1'b1;
      end
    end
    if (sys_init) begin
      csr_d = '0;
    end
  end

  // CSR register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_q <= '0;
    end else begin
      csr_q <= csr_d;
    end
  end

  // Interrupt FSM; ST_REARM holds irq low one cycle when a tick meets iack.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else if (sys_init) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (qtick_c && rearm_ok_c) begin
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (iack) begin
            state_q <= (qtick_c && rearm_ok_c) ? ST_REARM : ST_IDLE;
            irq_q   <= 1'b0;
          end else if (ie_clr_c) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end
        end
        ST_REARM: begin
          if (rearm_ok_c) begin
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  // Bus acknowledge follows the strobe by one cycle; read data travels with it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req_c;
      dat_q <= req_c ? csr_pack(csr_q) : '0;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq      = irq_q;
  assign ivec     = VECTOR;

endmodule
